// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
//   Shared constants for the data-memory arbiter slice.
//   OWN_CPU / OWN_DBG : encoding of the last_owner flag.
//   AW_DEF / DW_DEF   : default address / data widths of the data BRAM.
//   CNT_W             : width of the debug burst counter.
package dmem_arbiter_pkg;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

  localparam int AW_DEF = 11;
  localparam int DW_DEF = 32;

  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_arbiter_rr2.sv
// arb_rr2
//   Two-input round-robin picker with a burst-limit override.
//   Ports:
//     req[1:0]   in   request vector, bit 0 = CPU, bit 1 = debug
//     last_owner in   owner of the most recent grant (OWN_CPU / OWN_DBG)
//     force_cpu  in   debug burst limit reached: CPU wins a conflict
//     gnt[1:0]   out  one-hot grant (or zero when nobody requests)
module arb_rr2
  import dmem_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  input  logic       force_cpu,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b01) begin
      gnt = 2'b01;
    end else if (req == 2'b10) begin
      gnt = 2'b10;
    end else if (req == 2'b11) begin
      // Conflict: alternate owners unless the debug side has used up its burst.
      if (force_cpu || (last_owner == OWN_DBG)) begin
        gnt = 2'b01;
      end else begin
        gnt = 2'b10;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data BRAM between the CPU load/store path and a
//   read-only board-side debug port. Grants are combinational, the BRAM port
//   is driven in the grant cycle, and read data returns one cycle later with
//   a one-cycle valid strobe per requester.
//   Optional statistics counters are compiled in with `define DMEM_ARB_STATS_EN.
//   Ports:
//     clk, rst                          clock, synchronous active-high reset
//     cpu_req/we/addr/wdata             CPU request (held while stalled)
//     cpu_stall, cpu_rdata, cpu_rvalid  CPU stall and load return
//     dbg_req/addr                      debug read request (held until dbg_gnt)
//     dbg_gnt, dbg_rdata, dbg_rvalid    debug accept and read return
//     mem_en/we/addr/wdata, mem_rdata   BRAM port (1-cycle read latency)
//     stat_conflicts, stat_cpu_stalls   saturating counters (stats build only)
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW            = AW_DEF,
  parameter int DW            = DW_DEF,
  parameter int MAX_DBG_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_stall,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_rvalid,
  input  logic          dbg_req,
  input  logic [AW-1:0] dbg_addr,
  output logic          dbg_gnt,
  output logic [DW-1:0] dbg_rdata,
  output logic          dbg_rvalid,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
`ifdef DMEM_ARB_STATS_EN
  output logic [15:0]   stat_conflicts,
  output logic [15:0]   stat_cpu_stalls,
`endif
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DBG_BURST);

  logic             last_owner_reg, last_owner_next;
  logic [CNT_W-1:0] dbg_cnt_reg, dbg_cnt_next;
  logic             rd_pend_cpu_reg, rd_pend_cpu_next;
  logic             rd_pend_dbg_reg, rd_pend_dbg_next;
  logic [AW-1:0]    addr_hold_reg, addr_hold_next;
  logic [DW-1:0]    wdata_hold_reg, wdata_hold_next;
  logic [DW-1:0]    cpu_rdata_reg, cpu_rdata_next;
  logic [DW-1:0]    dbg_rdata_reg, dbg_rdata_next;

  logic [1:0] gnt_raw;
  logic       cpu_grant;
  logic       dbg_grant;

  arb_rr2 u_arb (
    .req        ({dbg_req, cpu_req}),
    .last_owner (last_owner_reg),
    .force_cpu  (dbg_cnt_reg == CNT_MAX),
    .gnt        (gnt_raw)
  );

  // Nothing is granted while reset is held, so every output reads zero then.
  assign cpu_grant = gnt_raw[0] & ~rst;
  assign dbg_grant = gnt_raw[1] & ~rst;

  // ---------------- next-state ----------------
  always_comb begin
    last_owner_next  = last_owner_reg;
    dbg_cnt_next     = dbg_cnt_reg;
    addr_hold_next   = addr_hold_reg;
    wdata_hold_next  = wdata_hold_reg;
    rd_pend_cpu_next = cpu_grant & ~cpu_we;
    rd_pend_dbg_next = dbg_grant;
    cpu_rdata_next   = rd_pend_cpu_reg ? mem_rdata : cpu_rdata_reg;
    dbg_rdata_next   = rd_pend_dbg_reg ? mem_rdata : dbg_rdata_reg;

    if (cpu_grant) begin
      last_owner_next = OWN_CPU;
      addr_hold_next  = cpu_addr;
      wdata_hold_next = cpu_wdata;
    end else if (dbg_grant) begin
      last_owner_next = OWN_DBG;
      addr_hold_next  = dbg_addr;
    end

    // Burst counter only measures how long the CPU has been kept waiting.
    if (cpu_grant || !cpu_req) begin
      dbg_cnt_next = '0;
    end else if (dbg_grant && (dbg_cnt_reg != CNT_MAX)) begin
      dbg_cnt_next = dbg_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner_reg  <= OWN_DBG;
      dbg_cnt_reg     <= '0;
      rd_pend_cpu_reg <= 1'b0;
      rd_pend_dbg_reg <= 1'b0;
      addr_hold_reg   <= '0;
      wdata_hold_reg  <= '0;
      cpu_rdata_reg   <= '0;
      dbg_rdata_reg   <= '0;
    end else begin
      last_owner_reg  <= last_owner_next;
      dbg_cnt_reg     <= dbg_cnt_next;
      rd_pend_cpu_reg <= rd_pend_cpu_next;
      rd_pend_dbg_reg <= rd_pend_dbg_next;
      addr_hold_reg   <= addr_hold_next;
      wdata_hold_reg  <= wdata_hold_next;
      cpu_rdata_reg   <= cpu_rdata_next;
      dbg_rdata_reg   <= dbg_rdata_next;
    end
  end

  // ---------------- outputs ----------------
  always_comb begin
    cpu_stall  = cpu_req & ~cpu_grant & ~rst;
    dbg_gnt    = dbg_grant;
    mem_en     = cpu_grant | dbg_grant;
    mem_we     = cpu_grant & cpu_we;   // debug side is read-only
    mem_addr   = addr_hold_reg;
    mem_wdata  = wdata_hold_reg;
    // Read data is forwarded in its return cycle, then held from the register.
    cpu_rvalid = rd_pend_cpu_reg & ~rst;
    dbg_rvalid = rd_pend_dbg_reg & ~rst;
    cpu_rdata  = cpu_rdata_next;
    dbg_rdata  = dbg_rdata_next;

    if (cpu_grant) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dbg_grant) begin
      mem_addr  = dbg_addr;
    end

    if (rst) begin
      mem_addr  = '0;
      mem_wdata = '0;
      cpu_rdata = '0;
      dbg_rdata = '0;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  logic [15:0] stat_conflicts_reg, stat_conflicts_next;
  logic [15:0] stat_cpu_stalls_reg, stat_cpu_stalls_next;

  always_comb begin
    stat_conflicts_next  = stat_conflicts_reg;
    stat_cpu_stalls_next = stat_cpu_stalls_reg;
    if (cpu_req && dbg_req && (stat_conflicts_reg != 16'hFFFF)) begin
      stat_conflicts_next = stat_conflicts_reg + 16'd1;
    end
    if (cpu_stall && (stat_cpu_stalls_reg != 16'hFFFF)) begin
      stat_cpu_stalls_next = stat_cpu_stalls_reg + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_conflicts_reg  <= '0;
      stat_cpu_stalls_reg <= '0;
    end else begin
      stat_conflicts_reg  <= stat_conflicts_next;
      stat_cpu_stalls_reg <= stat_cpu_stalls_next;
    end
  end

  assign stat_conflicts  = stat_conflicts_reg;
  assign stat_cpu_stalls = stat_cpu_stalls_reg;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Bench for dmem_arbiter (MAX_DBG_BURST = 2) with a behavioural BRAM and a
//   behavioural reference model of the arbitration rules. Stats checks are
//   compiled when DMEM_ARB_STATS_EN is defined.
module tb_dmem_arbiter;

  localparam int AW   = 11;
  localparam int DW   = 32;
  localparam int MAXB = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_stall;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic          dbg_req;
  logic [AW-1:0] dbg_addr;
  logic          dbg_gnt;
  logic [DW-1:0] dbg_rdata;
  logic          dbg_rvalid;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0]   stat_conflicts, stat_cpu_stalls;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_DBG_BURST(MAXB)) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_stall  (cpu_stall),
    .cpu_rdata  (cpu_rdata),
    .cpu_rvalid (cpu_rvalid),
    .dbg_req    (dbg_req),
    .dbg_addr   (dbg_addr),
    .dbg_gnt    (dbg_gnt),
    .dbg_rdata  (dbg_rdata),
    .dbg_rvalid (dbg_rvalid),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
`ifdef DMEM_ARB_STATS_EN
    .stat_conflicts  (stat_conflicts),
    .stat_cpu_stalls (stat_cpu_stalls),
`endif
    .mem_rdata  (mem_rdata)
  );

  // Behavioural single-port BRAM, one-cycle read latency.
  logic [DW-1:0] bram [0:2047];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        mem_rdata <= bram[mem_addr];
    end
  end

  // ---------------- reference model state ----------------
  int            m_last;       // 0 = CPU owned last grant, 1 = debug
  int            m_burst;      // debug grants in a row while the CPU waits
  bit            m_pc, m_pd;   // read return due this cycle
  logic [DW-1:0] m_pc_data, m_pd_data, m_cpu_hold, m_dbg_hold;
  logic [AW-1:0] m_addr_hold;
  logic [DW-1:0] ref_mem [0:15];
  logic          last_stall, last_gnt;
  int            cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then compare every output with the model at
  // the falling edge and advance the model past the coming rising edge.
  task automatic apply(input logic r, input logic cr, input logic cwe, input logic [AW-1:0] ca,
                       input logic [DW-1:0] cwd, input logic dr, input logic [AW-1:0] da);
    bit c_win, d_win;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_crd, e_drd;
    rst = r; cpu_req = cr; cpu_we = cwe; cpu_addr = ca; cpu_wdata = cwd;
    dbg_req = dr; dbg_addr = da;
    @(negedge clk);
    if (r) begin
      c_win = 0; d_win = 0; e_addr = '0; e_crd = '0; e_drd = '0;
    end else begin
      c_win  = cr && (!dr || m_last == 1 || m_burst >= MAXB);
      d_win  = dr && !c_win;
      e_addr = c_win ? ca : (d_win ? da : m_addr_hold);
      e_crd  = m_pc ? m_pc_data : m_cpu_hold;
      e_drd  = m_pd ? m_pd_data : m_dbg_hold;
    end
    chk("cpu_stall",  32'(cpu_stall),  32'(cr && !c_win && !r));
    chk("dbg_gnt",    32'(dbg_gnt),    32'(d_win));
    chk("mem_en",     32'(mem_en),     32'(c_win || d_win));
    chk("mem_we",     32'(mem_we),     32'(c_win && cwe));
    chk("mem_addr",   32'(mem_addr),   32'(e_addr));
    if (c_win && cwe) chk("mem_wdata", mem_wdata, cwd);
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_pc && !r));
    chk("dbg_rvalid", 32'(dbg_rvalid), 32'(m_pd && !r));
    chk("cpu_rdata",  cpu_rdata, e_crd);
    chk("dbg_rdata",  dbg_rdata, e_drd);
    $display("cyc=%0d rst=%0b creq=%0b we=%0b ca=%h dreq=%0b da=%h | stall=%0b gnt=%0b crv=%0b crd=%h drv=%0b drd=%h",
             cyc, r, cr, cwe, ca, dr, da, cpu_stall, dbg_gnt, cpu_rvalid, cpu_rdata, dbg_rvalid, dbg_rdata);
    last_stall = cpu_stall;
    last_gnt   = dbg_gnt;
    if (r) begin
      m_last = 1; m_burst = 0; m_pc = 0; m_pd = 0;
      m_cpu_hold = '0; m_dbg_hold = '0; m_addr_hold = '0;
    end else begin
      m_cpu_hold = e_crd;
      m_dbg_hold = e_drd;
      m_pc = c_win && !cwe;
      m_pd = d_win;
      m_pc_data = ref_mem[ca[3:0]];
      m_pd_data = ref_mem[da[3:0]];
      if (c_win && cwe) ref_mem[ca[3:0]] = cwd;
      if (c_win)      begin m_last = 0; m_addr_hold = ca; end
      else if (d_win) begin m_last = 1; m_addr_hold = da; end
      if (!cr || c_win) m_burst = 0;
      else if (d_win)   m_burst = (m_burst + 1 > MAXB) ? MAXB : m_burst + 1;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  typedef struct {
    logic          r, cr, cwe;
    logic [AW-1:0] ca;
    logic [DW-1:0] cwd;
    logic          dr;
    logic [AW-1:0] da;
    logic          stall, gnt, crv;
    logic [DW-1:0] crd;
    logic          drv;
    logic [DW-1:0] drd;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(logic r, logic cr, logic cwe, logic [DW-1:0] cwd, logic dr,
                              logic stall, logic gnt, logic crv, logic drv);
    vec_t v;
    v.r = r; v.cr = cr; v.cwe = cwe; v.ca = 11'h005; v.cwd = cwd;
    v.dr = dr; v.da = 11'h005;
    v.stall = stall; v.gnt = gnt; v.crv = crv; v.drv = drv;
    v.crd = (crv && !r) ? 32'hDEADBEEF : 32'h0;
    v.drd = (drv && !r) ? 32'hDEADBEEF : 32'h0;
    return v;
  endfunction

  logic          cr, cwe, dr;
  logic [AW-1:0] ca, da;
  logic [DW-1:0] cwd;
  int            run, max_run;
  bit            cpu_got;

  initial begin
    rst = 1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_addr = '0;
    m_last = 1; m_burst = 0; m_pc = 0; m_pd = 0;
    m_cpu_hold = '0; m_dbg_hold = '0; m_addr_hold = '0;
    m_pc_data = '0; m_pd_data = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;

    //                 r  cr we data          dr stall gnt crv drv
    tbl[0]  = mk(1, 0, 0, 32'h0,        0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 1, 1, 32'hDEADBEEF, 0, 0, 0, 0, 0);  // store
    tbl[2]  = mk(0, 1, 0, 32'h0,        0, 0, 0, 0, 0);  // load
    tbl[3]  = mk(0, 0, 0, 32'h0,        1, 0, 1, 1, 0);  // debug read
    tbl[4]  = mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 1);
    tbl[5]  = mk(1, 0, 0, 32'h0,        0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 1, 0, 32'h0,        1, 0, 0, 0, 0);  // contention x6
    tbl[7]  = mk(0, 1, 0, 32'h0,        1, 1, 1, 1, 0);
    tbl[8]  = mk(0, 1, 0, 32'h0,        1, 0, 0, 0, 1);
    tbl[9]  = mk(0, 1, 0, 32'h0,        1, 1, 1, 1, 0);
    tbl[10] = mk(0, 1, 0, 32'h0,        1, 0, 0, 0, 1);
    tbl[11] = mk(0, 1, 0, 32'h0,        1, 1, 1, 1, 0);
    tbl[12] = mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 1);
    tbl[13] = mk(0, 1, 0, 32'h0,        0, 0, 0, 0, 0);  // load, then reset
    tbl[14] = mk(1, 0, 0, 32'h0,        0, 0, 0, 0, 0);
    tbl[15] = mk(0, 1, 0, 32'h0,        1, 0, 0, 0, 0);  // CPU first after reset
    tbl[16] = mk(0, 1, 0, 32'h0,        1, 1, 1, 1, 0);
    tbl[17] = mk(0, 0, 0, 32'h0,        0, 0, 0, 0, 1);

    for (int i = 0; i < 18; i++) begin
      apply(tbl[i].r, tbl[i].cr, tbl[i].cwe, tbl[i].ca, tbl[i].cwd, tbl[i].dr, tbl[i].da);
      chk("tbl_stall", 32'(cpu_stall),  32'(tbl[i].stall));
      chk("tbl_gnt",   32'(dbg_gnt),    32'(tbl[i].gnt));
      chk("tbl_crv",   32'(cpu_rvalid), 32'(tbl[i].crv));
      chk("tbl_drv",   32'(dbg_rvalid), 32'(tbl[i].drv));
      if (tbl[i].crv || tbl[i].r) chk("tbl_crd", cpu_rdata, tbl[i].crd);
      if (tbl[i].drv || tbl[i].r) chk("tbl_drd", dbg_rdata, tbl[i].drd);
      if (tbl[i].r) chk("tbl_rst_en", 32'({mem_en, mem_we}), 32'h0);
      advance();
    end

    // Fill the 16 words used by the rest of the run.
    for (int i = 0; i < 16; i++) begin
      apply(0, 1, 1, 11'(i), $urandom, 0, '0);
      advance();
    end

    // Burst limit: debug streaming alone, then the CPU joins.
    for (int i = 0; i < 3; i++) begin
      apply(0, 0, 0, '0, '0, 1, 11'(i));
      advance();
    end
    run = 0; max_run = 0; cpu_got = 0;
    for (int i = 0; i < 6; i++) begin
      apply(0, 1, 0, 11'(i + 4), '0, 1, 11'(i + 8));
      if (dbg_gnt) run++;
      else begin run = 0; cpu_got = 1; end
      if (run > max_run) max_run = run;
      advance();
    end
    chk("burst_cpu_granted", 32'(cpu_got), 32'd1);
    chk("burst_max_dbg_le_limit", 32'(max_run > MAXB), 32'd0);

    // Randomised traffic obeying the hold-until-granted handshake.
    cr = 0; cwe = 0; ca = '0; cwd = '0; dr = 0; da = '0;
    for (int i = 0; i < 400; i++) begin
      logic r;
      r = ($urandom_range(0, 63) == 0);
      apply(r, cr, cwe, ca, cwd, dr, da);
      advance();
      if (r || !(cr && last_stall)) begin
        cr  = ($urandom_range(0, 3) != 0);
        cwe = $urandom_range(0, 1) == 1;
        ca  = 11'($urandom_range(0, 15));
        cwd = $urandom;
      end
      if (r || !dr || last_gnt) begin
        dr = ($urandom_range(0, 2) != 0);
        da = 11'($urandom_range(0, 15));
      end
    end

`ifdef DMEM_ARB_STATS_EN
    apply(1, 0, 0, '0, '0, 0, '0);
    advance();
    for (int i = 0; i < 10; i++) begin
      apply(0, 1, 0, 11'(i), '0, 1, 11'(i));
      advance();
    end
    apply(0, 0, 0, '0, '0, 0, '0);
    chk("stat_conflicts",  32'(stat_conflicts),  32'd10);
    chk("stat_cpu_stalls", 32'(stat_cpu_stalls), 32'd5);
    advance();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data BRAM between two requesters: the processor load/store path and the board-side readout/debug port.
- The debug port replaces the current hard `hld` override; it is read-only.
- Sits between the core datapath and the data_memory BRAM and drives all BRAM enable, write-enable, address and data pins.
- Stalls the core when it loses arbitration and returns read data with a valid strobe to each requester.

Parameters:
- AW, 11, BRAM word-address width.
- DW, 32, data width.
- MAX_DBG_BURST, 4, maximum consecutive debug grants while the CPU is waiting; range 1..15.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- cpu_req  in  1  CPU load/store request, held until not stalled
- cpu_we  in  1  1 = store, 0 = load
- cpu_addr  in  AW  CPU word address
- cpu_wdata  in  DW  store data
- cpu_stall  out  1  CPU request not granted this cycle
- cpu_rdata  out  DW  load data
- cpu_rvalid  out  1  cpu_rdata valid, one-cycle pulse
- dbg_req  in  1  debug read request, held until dbg_gnt
- dbg_addr  in  AW  debug word address
- dbg_gnt  out  1  debug request accepted this cycle
- dbg_rdata  out  DW  debug read data
- dbg_rvalid  out  1  dbg_rdata valid, one-cycle pulse
- mem_en  out  1  BRAM enable
- mem_we  out  1  BRAM write enable
- mem_addr  out  AW  BRAM address
- mem_wdata  out  DW  BRAM write data
- mem_rdata  in  DW  BRAM read data, 1-cycle latency

Behaviour:
- Grant logic:
  - Combinational from the current requests and the registered state.
  - At most one grant per cycle.
  - The BRAM port is driven in the grant cycle.
- Priority:
  - Only one requester: it wins.
  - Both requesting: the winner is the owner other than last_owner (round-robin).
  - Override: if dbg_cnt == MAX_DBG_BURST, the CPU wins.
- Registered state:
  - last_owner (0 = CPU, 1 = DBG).
  - dbg_cnt: 4-bit count of consecutive debug grants while cpu_req is high.
  - rd_pend_cpu, rd_pend_dbg: a read was issued last cycle.
- dbg_cnt:
  - Increments on a debug grant while cpu_req = 1.
  - Clears on any CPU grant or when cpu_req = 0.
  - Saturates at MAX_DBG_BURST.
- Stall and grant outputs:
  - cpu_stall = cpu_req & ~cpu_grant.
  - dbg_gnt = debug grant.
- BRAM drive:
  - Idle: mem_en = 0, mem_we = 0, mem_addr / mem_wdata hold their last values.
  - Debug grant: mem_we is forced to 0.
- Read return:
  - A granted read sets rd_pend_x.
  - The next cycle, x_rvalid = 1 and x_rdata = mem_rdata.
  - x_rdata is registered and holds until the next read for that requester.
- Stores produce no rvalid.
- Back-to-back grants are allowed every cycle; there are no bubbles.
- Simultaneous first requests after reset: the CPU wins, because last_owner resets to DBG.
- Reset:
  - All outputs 0.
  - last_owner = DBG, dbg_cnt = 0, pending flags cleared.
  - A read in flight when rst asserts produces no rvalid.
- Requester dropping req without a grant: legal; no state change except dbg_cnt clearing.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_conflicts[15:0] and stat_cpu_stalls[15:0].
  - stat_conflicts increments in cycles where both requests are high.
  - stat_cpu_stalls increments in cycles where cpu_stall = 1.
  - Both saturate at 16'hFFFF and clear on rst.
- Undefined: the ports and counters are absent; everything else is identical.

Decomposition:
- Shared package holds:
  - Owner encoding constants OWN_CPU = 1'b0, OWN_DBG = 1'b1.
  - Default widths AW_DEF = 11, DW_DEF = 32.
- One natural sub-module, arb_rr2: a two-input round-robin picker with burst-limit override. Returns a one-hot grant from req[1:0], last_owner and the force_cpu flag.
- Read-return registers and counters stay in the top block.

Test Plan:
- CPU store then load: store addr 0x005, data 0xDEADBEEF; load 0x005 the next cycle.
  - Required: cpu_stall = 0 in both cycles.
  - Required: cpu_rvalid pulses one cycle after the load with cpu_rdata = 0xDEADBEEF.
- Debug read only: dbg_req at addr 0x005.
  - Required: dbg_gnt = 1 in the same cycle, mem_we = 0.
  - Required: dbg_rvalid one cycle later with dbg_rdata = 0xDEADBEEF.
- Contention: both requests held high for 6 cycles from reset.
  - Required grant sequence: CPU, DBG, CPU, DBG, CPU, DBG.
  - Required: cpu_stall high exactly in the DBG-granted cycles.
- Burst limit: MAX_DBG_BURST = 2, cpu_req arrives while the debug side is being granted continuously.
  - Required: no more than 2 consecutive DBG grants with cpu_req high before a CPU grant; dbg_cnt returns to 0.
- Reset mid-read: CPU load granted, rst asserted the next cycle.
  - Required: cpu_rvalid = 0, all outputs 0; first post-reset simultaneous request grants the CPU.
- With DMEM_ARB_STATS_EN: 10 contention cycles.
  - Required: stat_conflicts = 10, stat_cpu_stalls = 5.
